// File: rtl/sdblock.sv
// Single-block SD read sequencer: CMD17, R1 and data-token polling, 512-byte sector streamed out as buffer writes.
// Optional SDBLOCK_CRC_EN checks the CRC16-CCITT trailer against the received data.
module sdblock #(
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] lba,
  input  logic        sdhc,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        buf_we,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy,
  input  logic        sd_timeout
);

  localparam int TRY_MAX = (TOKEN_TRIES > R1_TRIES) ? TOKEN_TRIES : R1_TRIES;
  localparam int TRY_W   = $clog2(TRY_MAX + 1);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_DESEL = 4'd1;
  localparam logic [3:0] ST_PRE   = 4'd2;
  localparam logic [3:0] ST_SEL   = 4'd3;
  localparam logic [3:0] ST_CMD   = 4'd4;
  localparam logic [3:0] ST_R1    = 4'd5;
  localparam logic [3:0] ST_TOKEN = 4'd6;
  localparam logic [3:0] ST_DATA  = 4'd7;
  localparam logic [3:0] ST_CRC   = 4'd8;
  localparam logic [3:0] ST_END   = 4'd9;

  // Engine handshake phase within each state
  localparam logic [1:0] PH_ISSUE   = 2'd0;
  localparam logic [1:0] PH_WAIT_HI = 2'd1;
  localparam logic [1:0] PH_WAIT_LO = 2'd2;

  logic [3:0]       state, state_n;
  logic [1:0]       phase, phase_n;
  logic [2:0]       step, step_n;
  logic [8:0]       byte_cnt, cnt_n;
  logic [TRY_W-1:0] tries, tries_n;
  logic [2:0]       err_n;
  logic [31:0]      lba_q;
  logic             sdhc_q;
  logic [31:0]      card_addr;
  logic             issue, we_n, fin, complete;

`ifdef SDBLOCK_CRC_EN
  logic [15:0] crc;
  logic [7:0]  crc_hi;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic [7:0]  b;
    r = c;
    b = d;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ b[7]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
      b = {b[6:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign card_addr = sdhc_q ? lba_q : {lba_q[22:0], 9'd0};
  assign complete  = (phase == PH_WAIT_LO) && !sd_busy;

  function automatic logic [1:0] cmd_for(input logic [3:0] s, input logic [2:0] k);
    if (s == ST_DESEL)                     return 2'd3;
    else if (s == ST_SEL)                  return 2'd2;
    else if (s == ST_END && k == 3'd0)     return 2'd3;
    else                                   return 2'd1;
  endfunction

  function automatic logic [7:0] out_for(input logic [3:0] s, input logic [2:0] k,
                                         input logic [31:0] a);
    if (s != ST_CMD) return 8'hFF;
    case (k)
      3'd0:    return 8'h51;
      3'd1:    return a[31:24];
      3'd2:    return a[23:16];
      3'd3:    return a[15:8];
      3'd4:    return a[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    phase_n = phase;
    step_n  = step;
    cnt_n   = byte_cnt;
    tries_n = tries;
    err_n   = err;
    issue   = 1'b0;
    we_n    = 1'b0;
    fin     = 1'b0;
    if (state == ST_IDLE) begin
      if (start) begin
        state_n = ST_DESEL;
        step_n  = '0;
        err_n   = '0;
        // An engine byte left over from a reset sequence must drain before the first issue
        if (sd_busy) phase_n = PH_ISSUE;
        else         issue   = 1'b1;
      end
    end else if (phase == PH_ISSUE) begin
      if (!sd_busy) issue = 1'b1;
    end else if (phase == PH_WAIT_HI) begin
      if (sd_busy) phase_n = PH_WAIT_LO;
    end else if (complete) begin
      issue = 1'b1;
      if (sd_timeout && state != ST_END) begin
        err_n   = 3'd4;
        state_n = ST_END;
        step_n  = '0;
      end else begin
        case (state)
          ST_DESEL: state_n = ST_PRE;
          ST_PRE:   state_n = ST_SEL;
          ST_SEL: begin
            state_n = ST_CMD;
            step_n  = '0;
          end
          ST_CMD: begin
            if (step == 3'd5) begin
              state_n = ST_R1;
              tries_n = TRY_W'(1);
            end else begin
              step_n = step + 3'd1;
            end
          end
          ST_R1: begin
            if (sd_din == 8'h00) begin
              state_n = ST_TOKEN;
              tries_n = TRY_W'(1);
            end else if (sd_din != 8'hFF) begin
              err_n   = 3'd1;
              state_n = ST_END;
              step_n  = '0;
            end else if (tries == TRY_W'(R1_TRIES)) begin
              err_n   = 3'd2;
              state_n = ST_END;
              step_n  = '0;
            end else begin
              tries_n = tries + TRY_W'(1);
            end
          end
          ST_TOKEN: begin
            if (sd_din == 8'hFE) begin
              state_n = ST_DATA;
              cnt_n   = '0;
            end else if (sd_din != 8'hFF || tries == TRY_W'(TOKEN_TRIES)) begin
              err_n   = 3'd3;
              state_n = ST_END;
              step_n  = '0;
            end else begin
              tries_n = tries + TRY_W'(1);
            end
          end
          ST_DATA: begin
            we_n  = 1'b1;
            cnt_n = byte_cnt + 9'd1;
            if (byte_cnt == 9'd511) begin
              state_n = ST_CRC;
              step_n  = '0;
            end
          end
          ST_CRC: begin
            if (step == 3'd0) begin
              step_n = 3'd1;
            end else begin
`ifdef SDBLOCK_CRC_EN
              if ({crc_hi, sd_din} != crc) err_n = 3'd5;
`endif
              state_n = ST_END;
              step_n  = '0;
            end
          end
          ST_END: begin
            if (step == 3'd0) begin
              step_n = 3'd1;
            end else begin
              issue   = 1'b0;
              fin     = 1'b1;
              state_n = ST_IDLE;
            end
          end
          default: begin
            issue   = 1'b0;
            state_n = ST_IDLE;
          end
        endcase
      end
    end
    if (issue) phase_n = PH_WAIT_HI;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase     <= PH_ISSUE;
      step      <= '0;
      byte_cnt  <= '0;
      tries     <= '0;
      err       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_we    <= 1'b0;
      sd_signal <= 1'b0;
      sd_cmd    <= 2'd3;
      sd_out    <= 8'hFF;
      lba_q     <= '0;
      sdhc_q    <= 1'b0;
`ifdef SDBLOCK_CRC_EN
      crc       <= '0;
      crc_hi    <= '0;
`endif
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      step      <= step_n;
      byte_cnt  <= cnt_n;
      tries     <= tries_n;
      err       <= err_n;
      busy      <= (state_n != ST_IDLE);
      done      <= fin;
      sd_signal <= issue;
      buf_we    <= we_n;
      if (issue) begin
        sd_cmd <= cmd_for(state_n, step_n);
        sd_out <= out_for(state_n, step_n, card_addr);
      end
      if (we_n) begin
        buf_addr <= byte_cnt;
        buf_data <= sd_din;
      end
      if (state == ST_IDLE && start) begin
        lba_q  <= lba;
        sdhc_q <= sdhc;
      end
`ifdef SDBLOCK_CRC_EN
      if (state == ST_TOKEN && state_n == ST_DATA) crc <= '0;
      else if (we_n)                               crc <= crc_upd(crc, sd_din);
      if (complete && state == ST_CRC && step == 3'd0) crc_hi <= sd_din;
`endif
    end
  end

endmodule

// File: tb/tb_sdblock.sv
// Scoreboard bench for sdblock: an SD card/engine model answers transfers, a reference model predicts issues, writes and done.
// Honours SDBLOCK_CRC_EN when predicting the CRC-mismatch outcome.
module tb_sdblock;

  localparam int R1_TRIES    = 8;
  localparam int TOKEN_TRIES = 4096;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] lba;
  logic        sdhc;
  logic        busy, done, buf_we, sd_signal;
  logic [2:0]  err;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_data, sd_out, sd_din;
  logic [1:0]  sd_cmd;
  logic        sd_busy, sd_timeout;

  sdblock #(.R1_TRIES(R1_TRIES), .TOKEN_TRIES(TOKEN_TRIES)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .lba(lba), .sdhc(sdhc),
    .busy(busy), .done(done), .err(err), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_we(buf_we), .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out),
    .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout)
  );

  initial clock = 1'b0;
  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [9:0]  exp_issue[$];
  logic [16:0] exp_wr[$];
  logic [2:0]  exp_done[$];

  logic [31:0] sc_lba;
  logic        sc_sdhc;
  int          sc_r1_delay, sc_tok_delay, sc_to_idx;
  logic [7:0]  sc_r1, sc_tok;
  logic [7:0]  sc_data[512];
  logic [15:0] sc_crc_tx;
  int          xfer_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < 512; i++) begin
      c = c ^ {sc_data[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic set_sc(input logic [31:0] l, input logic s, input int r1d, input logic [7:0] r1,
                        input int tokd, input logic [7:0] tok, input bit rnd_data,
                        input int to_idx, input bit crc_bad);
    sc_lba = l; sc_sdhc = s; sc_r1_delay = r1d; sc_r1 = r1;
    sc_tok_delay = tokd; sc_tok = tok; sc_to_idx = to_idx;
    for (int i = 0; i < 512; i++) sc_data[i] = rnd_data ? 8'($urandom) : 8'(i);
    sc_crc_tx = crc_ref() ^ (crc_bad ? 16'h0040 : 16'h0000);
  endtask

  // Reference model: expected engine issues, buffer writes and final error code
  task automatic build_exp();
    logic [31:0] a;
    logic [2:0]  e;
    logic [7:0]  rep;
    bit          go;
    e = 3'd0;
    a = sc_sdhc ? sc_lba : (sc_lba << 9);
    exp_issue.push_back({2'd3, 8'hFF});
    exp_issue.push_back({2'd1, 8'hFF});
    exp_issue.push_back({2'd2, 8'hFF});
    exp_issue.push_back({2'd1, 8'h51});
    exp_issue.push_back({2'd1, a[31:24]});
    exp_issue.push_back({2'd1, a[23:16]});
    exp_issue.push_back({2'd1, a[15:8]});
    exp_issue.push_back({2'd1, a[7:0]});
    exp_issue.push_back({2'd1, 8'hFF});
    if (sc_to_idx >= 0) begin
      while (exp_issue.size() > sc_to_idx + 1) void'(exp_issue.pop_back());
      e = 3'd4;
    end else begin
      go = 1'b0;
      for (int p = 0; p < R1_TRIES; p++) begin
        exp_issue.push_back({2'd1, 8'hFF});
        rep = (p < sc_r1_delay) ? 8'hFF : sc_r1;
        if (rep != 8'hFF) begin
          if (rep == 8'h00) go = 1'b1; else e = 3'd1;
          break;
        end
      end
      if (!go && e == 3'd0) e = 3'd2;
      if (go) begin
        go = 1'b0;
        for (int p = 0; p < TOKEN_TRIES; p++) begin
          exp_issue.push_back({2'd1, 8'hFF});
          rep = (p < sc_tok_delay) ? 8'hFF : sc_tok;
          if (rep != 8'hFF) begin
            if (rep == 8'hFE) go = 1'b1; else e = 3'd3;
            break;
          end
        end
        if (!go && e == 3'd0) e = 3'd3;
      end
      if (go) begin
        for (int i = 0; i < 512; i++) begin
          exp_issue.push_back({2'd1, 8'hFF});
          exp_wr.push_back({9'(i), sc_data[i]});
        end
        exp_issue.push_back({2'd1, 8'hFF});
        exp_issue.push_back({2'd1, 8'hFF});
`ifdef SDBLOCK_CRC_EN
        if (crc_ref() != sc_crc_tx) e = 3'd5;
`endif
      end
    end
    exp_issue.push_back({2'd3, 8'hFF});
    exp_issue.push_back({2'd1, 8'hFF});
    exp_done.push_back(e);
  endtask

  // SD card behind the byte engine
  initial begin
    logic [1:0] c;
    logic [7:0] o, reply;
    logic [7:0] resp[$];
    int         idx, cmd_cnt, lat;
    bit         cs_low, pend_gap;
    sd_busy = 1'b0; sd_din = 8'hFF; sd_timeout = 1'b0;
    cs_low = 1'b0; cmd_cnt = 0; pend_gap = 1'b0;
    forever begin
      @(negedge clock);
      if (pend_gap && reset_n) check("issue_gap", 32'(sd_signal | done), 32'd1);
      pend_gap = 1'b0;
      if (sd_signal && !sd_busy) begin
        c = sd_cmd; o = sd_out; idx = xfer_idx; xfer_idx++;
        reply = 8'hFF;
        if (c == 2'd3) begin
          cs_low = 1'b0; cmd_cnt = 0; resp.delete();
        end else if (c == 2'd2) begin
          cs_low = 1'b1;
        end else if (c == 2'd1 && cs_low) begin
          if (resp.size() > 0) reply = resp.pop_front();
          else if ((cmd_cnt == 0 && o == 8'h51) || (cmd_cnt > 0 && cmd_cnt < 6)) begin
            cmd_cnt++;
            if (cmd_cnt == 6) begin
              for (int i = 0; i < sc_r1_delay; i++) resp.push_back(8'hFF);
              resp.push_back(sc_r1);
              for (int i = 0; i < sc_tok_delay; i++) resp.push_back(8'hFF);
              resp.push_back(sc_tok);
              for (int i = 0; i < 512; i++) resp.push_back(sc_data[i]);
              resp.push_back(sc_crc_tx[15:8]);
              resp.push_back(sc_crc_tx[7:0]);
            end
          end
        end
        lat = $urandom_range(1, 2);
        @(negedge clock);
        sd_busy = 1'b1; sd_timeout = 1'b0;
        repeat (lat) @(negedge clock);
        sd_din = reply;
        sd_timeout = (idx == sc_to_idx);
        sd_busy = 1'b0;
        pend_gap = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an issue, write or done
  initial begin
    logic [9:0]  ei;
    logic [16:0] ew;
    logic [2:0]  ed;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n) begin
        if (sd_signal) begin
          check("issue_while_busy", 32'(sd_busy), 32'd0);
          if (exp_issue.size() == 0) unexpected("unexpected_issue");
          else begin
            ei = exp_issue.pop_front();
            check("issue_cmd", 32'(sd_cmd), 32'(ei[9:8]));
            if (ei[9:8] == 2'd1) check("issue_out", 32'(sd_out), 32'(ei[7:0]));
          end
        end
        if (buf_we) begin
          if (exp_wr.size() == 0) unexpected("unexpected_write");
          else begin
            ew = exp_wr.pop_front();
            check("buf_addr", 32'(buf_addr), 32'(ew[16:8]));
            check("buf_data", 32'(buf_data), 32'(ew[7:0]));
          end
        end
        if (done) begin
          check("busy_at_done", 32'(busy), 32'd0);
          if (exp_done.size() == 0) unexpected("unexpected_done");
          else begin
            ed = exp_done.pop_front();
            check("done_err", 32'(err), 32'(ed));
          end
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_buf_addr", 32'(buf_addr), 32'd0);
    check("rst_buf_data", 32'(buf_data), 32'd0);
    check("rst_buf_we", 32'(buf_we), 32'd0);
    check("rst_sd_signal", 32'(sd_signal), 32'd0);
    check("rst_sd_cmd", 32'(sd_cmd), 32'd3);
    check("rst_sd_out", 32'(sd_out), 32'hFF);
  endtask

  task automatic flush_and_reset();
    exp_issue.delete(); exp_wr.delete(); exp_done.delete();
    reset_n = 1'b0;
    repeat (8) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic run_seq(input bit poke_start, input bit reset_mid);
    int n;
    build_exp();
    xfer_idx = 0;
    @(negedge clock);
    lba = sc_lba; sdhc = sc_sdhc; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("first_issue_timing", 32'(sd_signal), 32'd1);
    if (poke_start || reset_mid) begin
      n = 0;
      while (n < 20000 && exp_wr.size() > (reset_mid ? 400 : 500)) begin
        @(negedge clock); n++;
      end
      if (n == 20000) begin
        unexpected("data_phase_timeout");
        flush_and_reset();
        return;
      end
      if (reset_mid) begin
        exp_issue.delete(); exp_wr.delete(); exp_done.delete();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_reset_vals();
        repeat (8) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        return;
      end
      start = 1'b1; lba = $urandom; sdhc = ~sc_sdhc;
      @(negedge clock);
      start = 1'b0;
    end
    n = 0;
    while (n < 30000 && exp_done.size() != 0) begin
      @(posedge clock); n++;
    end
    if (exp_done.size() != 0) begin
      unexpected("done_timeout");
      flush_and_reset();
      return;
    end
    repeat (3) @(negedge clock);
    check("leftover_issues", 32'(exp_issue.size()), 32'd0);
    check("leftover_writes", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; lba = '0; sdhc = 1'b0;
    sc_to_idx = -1; sc_r1 = 8'h00; sc_tok = 8'hFE; sc_r1_delay = 0; sc_tok_delay = 0;
    sc_lba = '0; sc_sdhc = 1'b0; sc_crc_tx = '0; xfer_idx = 0;
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    set_sc(32'd5, 1'b0, 2, 8'h00, 10, 8'hFE, 1'b0, -1, 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc(32'h12345678, 1'b1, $urandom_range(0, 6), 8'h00, $urandom_range(0, 30), 8'hFE, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc($urandom, 1'b0, 1, 8'h05, 3, 8'hFE, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc($urandom, 1'b1, 20, 8'h00, 3, 8'hFE, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc($urandom, 1'b0, 0, 8'h00, 4, 8'hFC, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc($urandom, 1'b1, 3, 8'h00, 5000, 8'hFE, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc($urandom, 1'b0, 2, 8'h00, 5, 8'hFE, 1'b1, $urandom_range(3, 8), 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc($urandom, 1'b1, 1, 8'h00, 2, 8'hFE, 1'b1, -1, 1'b0);
    run_seq(1'b1, 1'b0);
    set_sc($urandom, 1'b0, 1, 8'h00, 2, 8'hFE, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b1);
    set_sc($urandom, 1'b0, 7, 8'h00, $urandom_range(0, 40), 8'hFE, 1'b1, -1, 1'b0);
    run_seq(1'b0, 1'b0);
    set_sc($urandom, 1'b1, $urandom_range(0, 7), 8'h00, $urandom_range(0, 40), 8'hFE, 1'b1, -1, 1'b1);
    run_seq(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
